gate_sweep_ctrl: RTL and testbench

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

---
 rtl/gate_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate under test through {a,b} = 00,01,10,11 and checks its output against a|b.
// Optional first-failure log ports are enabled by defining GATE_SWEEP_FAILLOG_EN.
module gate_sweep_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
`ifdef GATE_SWEEP_FAILLOG_EN
    ,
    output logic       fail_valid,
    output logic [1:0] fail_vec
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] vec_q,   vec_d;
    logic [7:0] dwell_q, dwell_d;
    logic [2:0] err_q,   err_d;
    logic       pass_q,  pass_d;

    logic       driving;
    logic       mismatch;
    logic       accept;

    assign driving  = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign mismatch = (state_q == S_SAMPLE) && (c != (vec_q[1] | vec_q[0]));
    assign accept   = (state_q == S_IDLE) && start;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= 2'd0;
            dwell_q <= 8'd0;
            err_q   <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        dwell_d = dwell_q;
        err_d   = err_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DRIVE;
                    vec_d   = 2'd0;
                    dwell_d = 8'd0;
                    err_d   = 3'd0;
                    pass_d  = 1'b0;
                end
            end
            S_DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 3'd1;
                end
                if (vec_q == 2'd3) begin
                    // pass is registered here so it is already valid during the done pulse
                    state_d = S_DONE;
                    pass_d  = (err_q == 3'd0) && !mismatch;
                end else begin
                    state_d = S_DRIVE;
                    vec_d   = vec_q + 2'd1;
                    dwell_d = 8'd0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign a       = driving & vec_q[1];
    assign b       = driving & vec_q[0];
    assign busy    = driving;
    assign done    = (state_q == S_DONE);
    assign pass    = pass_q;
    assign err_cnt = err_q;

`ifdef GATE_SWEEP_FAILLOG_EN
    logic       fail_valid_q, fail_valid_d;
    logic [1:0] fail_vec_q,   fail_vec_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    // only the first mismatch of a sweep is kept
    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        if (accept) begin
            fail_valid_d = 1'b0;
            fail_vec_d   = 2'd0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: stimulus pushes expected sweep results, monitors check them on done.
module tb_gate_sweep_ctrl;

    localparam int DW0 = 4;
    localparam int DW1 = 1;

    typedef struct {
        int         done_cyc;
        logic [2:0] err;
        logic       pass;
        logic       fv;
        logic [1:0] fvec;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic a0, b0, c0, busy0, done0, pass0;
    logic a1, b1, c1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic fv0, fv1;
    logic [1:0] fvec0, fvec1;
    int mode0 = 0;
    int mode1 = 0;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_sweep_ctrl #(.DWELL(DW0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .c(c0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef GATE_SWEEP_FAILLOG_EN
        , .fail_valid(fv0), .fail_vec(fvec0)
`endif
    );

    gate_sweep_ctrl #(.DWELL(DW1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef GATE_SWEEP_FAILLOG_EN
        , .fail_valid(fv1), .fail_vec(fvec1)
`endif
    );

`ifndef GATE_SWEEP_FAILLOG_EN
    assign fv0 = 1'b0;
    assign fv1 = 1'b0;
    assign fvec0 = 2'd0;
    assign fvec1 = 2'd0;
`endif

    // gate models: 0 = OR, 1 = output stuck at 0, otherwise NOR
    always_comb begin
        case (mode0)
            0: c0 = a0 | b0;
            1: c0 = 1'b0;
            default: c0 = ~(a0 | b0);
        endcase
        case (mode1)
            0: c1 = a1 | b1;
            1: c1 = 1'b0;
            default: c1 = ~(a1 | b1);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [2:0] err,
                           input logic pss, input logic fv, input logic [1:0] fvec);
        check({tag, "_done_cycle"}, cyc, e.done_cyc);
        check({tag, "_err_cnt"}, {29'd0, err}, {29'd0, e.err});
        check({tag, "_pass"}, {31'd0, pss}, {31'd0, e.pass});
`ifdef GATE_SWEEP_FAILLOG_EN
        check({tag, "_fail_valid"}, {31'd0, fv}, {31'd0, e.fv});
        if (e.fv) check({tag, "_fail_vec"}, {30'd0, fvec}, {30'd0, e.fvec});
`endif
    endtask

    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) check("dut0_unexpected_done", 1, 0);
            else compare("dut0", q0.pop_front(), err0, pass0, fv0, fvec0);
        end
        if (done1) begin
            if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
            else compare("dut1", q1.pop_front(), err1, pass1, fv1, fvec1);
        end
    end

    // pulses start for one edge; returns the cycle count of the accepting edge
    task automatic pulse_start0(output int acc);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        acc = cyc;
    endtask

    task automatic pulse_start1(output int acc);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        acc = cyc;
    endtask

    task automatic push0(input int acc, input logic [2:0] err, input logic pss,
                         input logic fv, input logic [1:0] fvec);
        exp_t e;
        e.done_cyc = acc + 4 * (DW0 + 1);
        e.err = err;
        e.pass = pss;
        e.fv = fv;
        e.fvec = fvec;
        q0.push_back(e);
    endtask

    initial begin
        int acc;
        exp_t e;

        repeat (3) @(negedge clk);
        check("reset_dut0_outputs", {29'd0, a0, b0, busy0, done0, pass0}, 32'd0);
        check("reset_dut0_err_cnt", {29'd0, err0}, 32'd0);
        check("reset_dut1_outputs", {27'd0, a1, b1, busy1, done1, pass1}, 32'd0);
        rst = 1'b0;

        // correct OR gate: each vector held 5 cycles, done at cycle 20
        mode0 = 0;
        pulse_start0(acc);
        push0(acc, 3'd0, 1'b1, 1'b0, 2'd0);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("or_sweep_busy_ab", {29'd0, busy0, a0, b0}, {29'd0, 1'b1, 2'(j / 5)});
        end
        @(negedge clk);
        check("or_sweep_end_outputs", {29'd0, done0, busy0, a0, b0}, 32'h8 >> 0 == 0 ? 0 : {28'd0, 4'b1000});
        repeat (5) @(negedge clk);
        check("idle_hold_pass", {31'd0, pass0}, 32'd1);
        check("idle_hold_err", {29'd0, err0}, 32'd0);

        // output stuck at 0: vectors 01,10,11 mismatch
        mode0 = 1;
        pulse_start0(acc);
        push0(acc, 3'd3, 1'b0, 1'b1, 2'b01);
        repeat (25) @(negedge clk);

        // NOR substituted: all four vectors mismatch
        mode0 = 2;
        pulse_start0(acc);
        push0(acc, 3'd4, 1'b0, 1'b1, 2'b00);
        repeat (25) @(negedge clk);
        check("nor_idle_err", {29'd0, err0}, 32'd4);

        // start re-pulsed mid-sweep (edge 3), at edge 20 and while in DONE (edge 21)
        mode0 = 0;
        pulse_start0(acc);
        push0(acc, 3'd0, 1'b1, 1'b0, 2'd0);
        for (int j = 0; j <= 30; j++) begin
            @(negedge clk);
            start0 = (j == 2 || j == 19 || j == 20);
            if (j > 21) check("repulse_busy_low", {31'd0, busy0}, 32'd0);
        end
        start0 = 1'b0;

        // reset at cycle 7 with a NOR gate (one error already counted)
        mode0 = 2;
        pulse_start0(acc);
        for (int j = 0; j <= 7; j++) begin
            @(negedge clk);
            if (j == 5) check("pre_reset_err", {29'd0, err0}, 32'd1);
            rst = (j == 6);
            if (j == 7) begin
                check("post_reset_ab_busy", {29'd0, a0, b0, busy0}, 32'd0);
                check("post_reset_err", {29'd0, err0}, 32'd0);
            end
        end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post_reset_idle_busy", {31'd0, busy0}, 32'd0);

        // DWELL=1: done at cycle 8
        mode1 = 0;
        pulse_start1(acc);
        e.done_cyc = acc + 4 * (DW1 + 1);
        e.err = 3'd0; e.pass = 1'b1; e.fv = 1'b0; e.fvec = 2'd0;
        q1.push_back(e);
        repeat (12) @(negedge clk);

        mode1 = 1;
        pulse_start1(acc);
        e.done_cyc = acc + 4 * (DW1 + 1);
        e.err = 3'd3; e.pass = 1'b0; e.fv = 1'b1; e.fvec = 2'b01;
        q1.push_back(e);
        repeat (12) @(negedge clk);

        check("dut0_queue_drained", q0.size(), 0);
        check("dut1_queue_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
